// File: rtl/sat_bin_pkg.sv
// Shared literal encoding, loader FSM states and literal legality helper.
// Latency: none (definitions only).
// Backpressure: n/a.
// Contents: LIT_* literal codes, state_t loader FSM enum, lit_is_legal().
package sat_bin_pkg;

  // Two bits per variable: absent, positive, negative; 2'b11 is never a valid literal.
  localparam logic [1:0] LIT_NONE = 2'b00;
  localparam logic [1:0] LIT_POS  = 2'b01;
  localparam logic [1:0] LIT_NEG  = 2'b10;
  localparam logic [1:0] LIT_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic lit_is_legal(input logic [1:0] lit);
    return lit != LIT_ILL;
  endfunction

endpackage

// File: rtl/clause_len_counter.sv
// Sanitises a clause word (illegal literals -> absent) and counts present literals.
// Latency: purely combinational.
// Backpressure: none; output follows input.
// Ports: word_i raw clause word; clean_o sanitised word; len_o present-literal
//        count; illegal_o high if any literal was 2'b11.
module clause_len_counter
  import sat_bin_pkg::*;
#(
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_C_LEN = 4
) (
  input  logic [NUM_VARS*2-1:0]  word_i,
  output logic [NUM_VARS*2-1:0]  clean_o,
  output logic [WIDTH_C_LEN-1:0] len_o,
  output logic                   illegal_o
);

  always_comb begin
    clean_o   = '0;
    len_o     = '0;
    illegal_o = 1'b0;
    for (int j = 0; j < NUM_VARS; j++) begin
      if (!lit_is_legal(word_i[2*j +: 2])) begin
        // Dropped from the word and from the count, but remembered.
        illegal_o = 1'b1;
      end else if (word_i[2*j +: 2] != LIT_NONE) begin
        clean_o[2*j +: 2] = word_i[2*j +: 2];
        len_o             = len_o + WIDTH_C_LEN'(1);
      end
    end
  end

endmodule

// File: rtl/clause_bin_loader.sv
// Fetches one clause bin from clause memory and writes every clause_array row in order.
// Latency: row 0 written 3 cycles after start is accepted, one row per cycle, done 1 cycle after last row.
// Backpressure: none; memory must return data the cycle after rd_en_o, array accepts a row every cycle.
// Ports: clk/rst (sync, active-high); start_i, base_addr_i, num_clauses_i load request;
//        rd_en_o, rd_addr_o, rd_data_i clause memory; wr_o, clause_o, clause_len_o array write;
//        busy_o, done_o, err_o status.
module clause_bin_loader
  import sat_bin_pkg::*;
#(
  parameter  int NUM_CLAUSES = 8,
  parameter  int NUM_VARS    = 8,
  parameter  int WIDTH_C_LEN = 4,
  parameter  int WIDTH_ADDR  = 8,
  localparam int CNT_W       = $clog2(NUM_CLAUSES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [WIDTH_ADDR-1:0]   base_addr_i,
  input  logic [CNT_W-1:0]        num_clauses_i,
  output logic                    rd_en_o,
  output logic [WIDTH_ADDR-1:0]   rd_addr_o,
  input  logic [NUM_VARS*2-1:0]   rd_data_i,
  output logic [NUM_CLAUSES-1:0]  wr_o,
  output logic [NUM_VARS*2-1:0]   clause_o,
  output logic [WIDTH_C_LEN-1:0]  clause_len_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  // idx runs through FETCH (0..NUM_CLAUSES-1) and on through the two DRAIN cycles.
  localparam int IDX_W  = $clog2(NUM_CLAUSES + 2);
  localparam int ROW_W  = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
  localparam int WORD_W = NUM_VARS * 2;

  state_t                  state_q, state_d;
  logic [WIDTH_ADDR-1:0]   base_q;
  logic [CNT_W-1:0]        n_q;
  logic [CNT_W-1:0]        n_clamped;
  logic [IDX_W-1:0]        idx_q;
  logic                    start_acc;
  logic                    issue;
  logic                    row_live;

  // Stage 1: row issued last cycle; its memory word is on rd_data_i now.
  logic                    s1_vld;
  logic                    s1_zero;
  logic [ROW_W-1:0]        s1_row;
  logic [WORD_W-1:0]       s1_word;
  logic [WORD_W-1:0]       s1_clean;
  logic [WIDTH_C_LEN-1:0]  s1_len;
  logic                    s1_illegal;
  logic                    err_q;

  assign start_acc = (state_q == ST_IDLE) && start_i;
  assign issue     = (state_q == ST_FETCH);
  assign row_live  = issue && (32'(idx_q) < 32'(n_q));
  assign n_clamped = (32'(num_clauses_i) > NUM_CLAUSES) ? CNT_W'(NUM_CLAUSES) : num_clauses_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_FETCH;
      ST_FETCH: if (idx_q == IDX_W'(NUM_CLAUSES - 1)) state_d = ST_DRAIN;
      ST_DRAIN: if (idx_q == IDX_W'(NUM_CLAUSES + 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    rd_en_o   = row_live;
    rd_addr_o = row_live ? (base_q + WIDTH_ADDR'(idx_q)) : '0;
    busy_o    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    done_o    = (state_q == ST_DONE);
  end

  // Request capture and row index
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      n_q    <= '0;
      idx_q  <= '0;
    end else if (start_acc) begin
      base_q <= base_addr_i;
      n_q    <= n_clamped;
      idx_q  <= '0;
    end else if (busy_o) begin
      idx_q  <= idx_q + IDX_W'(1);
    end
  end

  // Zero rows never read memory, so whatever sits on rd_data_i is masked off.
  assign s1_word = s1_zero ? '0 : rd_data_i;

  clause_len_counter #(
    .NUM_VARS    (NUM_VARS),
    .WIDTH_C_LEN (WIDTH_C_LEN)
  ) u_len (
    .word_i    (s1_word),
    .clean_o   (s1_clean),
    .len_o     (s1_len),
    .illegal_o (s1_illegal)
  );

  // Two-stage write pipeline; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld       <= 1'b0;
      s1_zero      <= 1'b0;
      s1_row       <= '0;
      wr_o         <= '0;
      clause_o     <= '0;
      clause_len_o <= '0;
      err_q        <= 1'b0;
    end else begin
      s1_vld  <= issue;
      s1_zero <= !row_live;
      s1_row  <= ROW_W'(idx_q);
      wr_o    <= s1_vld ? (NUM_CLAUSES'(1) << s1_row) : '0;
      if (s1_vld) begin
        clause_o     <= s1_clean;
        clause_len_o <= s1_len;
      end
      if (start_acc)
        err_q <= 1'b0;
      else if (s1_vld && s1_illegal)
        err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

endmodule
